// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: mult/div op encoding, Tuse/Tnew widths and
// the shadow-stage record used by the hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned TNEW_W = 3;
    localparam logic [TNEW_W-1:0] TUSE_NEVER = 3'd7;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_HILO = 2'b11
    } md_op_e;

    typedef struct packed {
        logic [4:0]        a3;
        logic              we;
        logic [TNEW_W-1:0] tnew;
    } stage_shadow_t;

    // Tnew counts down one per stage and saturates at 0.
    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t != '0) ? t - 1'b1 : '0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_stage_hazard_cmp.sv
// Combinational rs/rt data-hazard check of the D-stage instruction against one
// shadowed downstream stage.
module stage_hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [TNEW_W-1:0] tuse_rs_i,
    input  logic [TNEW_W-1:0] tuse_rt_i,
    input  stage_shadow_t     stage_i,
    output logic              stall_rs_o,
    output logic              stall_rt_o
);

    // Tuse == Tnew is forwarded, so only a strictly later result stalls.
    always_comb begin
        stall_rs_o = stage_i.we && (stage_i.a3 == rs_i) && (rs_i != 5'd0) &&
                     (tuse_rs_i != TUSE_NEVER) && (tuse_rs_i < stage_i.tnew);
        stall_rt_o = stage_i.we && (stage_i.a3 == rt_i) && (rt_i != 5'd0) &&
                     (tuse_rt_i != TUSE_NEVER) && (tuse_rt_i < stage_i.tnew);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush producer for the 5-stage pipeline: shadow E/M registers, Tuse/Tnew
// comparison and mult/div busy tracking. HAZARD_STALL_CNT_EN adds a stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rs_D_I,
    input  logic [4:0]        rt_D_I,
    input  logic [TNEW_W-1:0] Tuse_rs_D_I,
    input  logic [TNEW_W-1:0] Tuse_rt_D_I,
    input  logic [4:0]        A3_D_I,
    input  logic              RegWrite_D_I,
    input  logic [TNEW_W-1:0] Tnew_D_I,
    input  logic [1:0]        md_op_D_I,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0]       stall_cnt_O,
`endif
    output logic              Stall_O,
    output logic              Flush_DE_O
);

    localparam int unsigned MdMax  = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned MdCntW = $clog2(MdMax + 1);

    stage_shadow_t     e_q, e_d, m_q, m_d;
    logic [MdCntW-1:0] md_cnt_q, md_cnt_d;
    logic              stall_rs_e, stall_rt_e, stall_rs_m, stall_rt_m;
    logic              md_busy, stall_md;

    stage_hazard_cmp u_cmp_e (
        .rs_i       (rs_D_I),
        .rt_i       (rt_D_I),
        .tuse_rs_i  (Tuse_rs_D_I),
        .tuse_rt_i  (Tuse_rt_D_I),
        .stage_i    (e_q),
        .stall_rs_o (stall_rs_e),
        .stall_rt_o (stall_rt_e)
    );

    stage_hazard_cmp u_cmp_m (
        .rs_i       (rs_D_I),
        .rt_i       (rt_D_I),
        .tuse_rs_i  (Tuse_rs_D_I),
        .tuse_rt_i  (Tuse_rt_D_I),
        .stage_i    (m_q),
        .stall_rs_o (stall_rs_m),
        .stall_rt_o (stall_rt_m)
    );

    always_comb begin
        md_busy    = (md_cnt_q != '0);
        stall_md   = (md_op_D_I != MD_NONE) && md_busy;
        Stall_O    = stall_rs_e | stall_rt_e | stall_rs_m | stall_rt_m | stall_md;
        Flush_DE_O = Stall_O;
    end

    // E mirrors the bubble injected into D/E; M always advances.
    always_comb begin
        e_d = '0;
        if (!Stall_O) begin
            e_d.a3   = A3_D_I;
            e_d.we   = RegWrite_D_I && (A3_D_I != 5'd0);
            e_d.tnew = tnew_dec(Tnew_D_I);
        end
        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (!Stall_O && (md_op_D_I == MD_MULT)) begin
            md_cnt_d = MdCntW'(MULT_CYC);
        end else if (!Stall_O && (md_op_D_I == MD_DIV)) begin
            md_cnt_d = MdCntW'(DIV_CYC);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - MdCntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            md_cnt_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (Stall_O) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_O = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl; also checks stall_cnt_O when
// HAZARD_STALL_CNT_EN is defined.
module tb_hazard_ctrl;

    typedef struct {
        string      name;
        bit         rst;
        bit         chk;
        logic [4:0] rs;
        logic [2:0] tuse_rs;
        logic [4:0] rt;
        logic [2:0] tuse_rt;
        logic [4:0] a3;
        logic       we;
        logic [2:0] tnew;
        logic [1:0] md;
        logic       exp_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D_I, rt_D_I, A3_D_I;
    logic [2:0]  Tuse_rs_D_I, Tuse_rt_D_I, Tnew_D_I;
    logic        RegWrite_D_I;
    logic [1:0]  md_op_D_I;
    logic        Stall_O, Flush_DE_O;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_O;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_D_I       (rs_D_I),
        .rt_D_I       (rt_D_I),
        .Tuse_rs_D_I  (Tuse_rs_D_I),
        .Tuse_rt_D_I  (Tuse_rt_D_I),
        .A3_D_I       (A3_D_I),
        .RegWrite_D_I (RegWrite_D_I),
        .Tnew_D_I     (Tnew_D_I),
        .md_op_D_I    (md_op_D_I),
`ifdef HAZARD_STALL_CNT_EN
        .stall_cnt_O  (stall_cnt_O),
`endif
        .Stall_O      (Stall_O),
        .Flush_DE_O   (Flush_DE_O)
    );

    function automatic vec_t mk(input string name, input bit rst, input bit chk,
                                input logic [4:0] rs, input logic [2:0] tuse_rs,
                                input logic [4:0] rt, input logic [2:0] tuse_rt,
                                input logic [4:0] a3, input logic we,
                                input logic [2:0] tnew, input logic [1:0] md,
                                input logic exp_stall);
        vec_t v;
        v.name = name; v.rst = rst; v.chk = chk;
        v.rs = rs; v.tuse_rs = tuse_rs; v.rt = rt; v.tuse_rt = tuse_rt;
        v.a3 = a3; v.we = we; v.tnew = tnew; v.md = md; v.exp_stall = exp_stall;
        return v;
    endfunction

    // Inputs change #1 after posedge; outputs are sampled on the negedge.
    task automatic apply(input vec_t v);
        reset        = v.rst;
        rs_D_I       = v.rs;
        Tuse_rs_D_I  = v.tuse_rs;
        rt_D_I       = v.rt;
        Tuse_rt_D_I  = v.tuse_rt;
        A3_D_I       = v.a3;
        RegWrite_D_I = v.we;
        Tnew_D_I     = v.tnew;
        md_op_D_I    = v.md;
        @(negedge clk);
        if (v.chk) begin
            n_vec++;
            if ({Stall_O, Flush_DE_O} != {v.exp_stall, v.exp_stall}) begin
                n_fail++;
                $display("FAIL %s: stall/flush got %b%b want %b%b", v.name,
                         Stall_O, Flush_DE_O, v.exp_stall, v.exp_stall);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single-source instruction helper: rt unused (Tuse never).
    task automatic cyc(input string name, input bit rst, input bit chk,
                       input logic [4:0] rs, input logic [2:0] tuse_rs,
                       input logic [4:0] a3, input logic we, input logic [2:0] tnew,
                       input logic [1:0] md, input logic exp_stall);
        apply(mk(name, rst, chk, rs, tuse_rs, 5'd0, 3'd7, a3, we, tnew, md, exp_stall));
    endtask

`ifdef HAZARD_STALL_CNT_EN
    task automatic check_cnt(input string name, input logic [31:0] exp);
        n_vec++;
        if (stall_cnt_O != exp) begin
            n_fail++;
            $display("FAIL %s: stall_cnt_O got %0d want %0d", name, stall_cnt_O, exp);
        end
    endtask
`endif

    vec_t vecs[$];

    initial begin
        //                 name        rst chk rs  tu  rt  tu  a3  we tnew md   exp
        vecs.push_back(mk("reset",      1, 0, 0,  7,  0,  7,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("rst_state",  0, 1, 0,  7,  0,  7,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("lw8",        0, 1, 0,  7,  0,  7,  8,  1, 3, 2'd0, 0));
        vecs.push_back(mk("lduse_e",    0, 1, 8,  0,  9,  0, 10,  1, 2, 2'd0, 1));
        vecs.push_back(mk("lduse_m",    0, 1, 8,  0,  9,  0, 10,  1, 2, 2'd0, 1));
        vecs.push_back(mk("lduse_rel",  0, 1, 8,  0,  9,  0, 10,  1, 2, 2'd0, 0));
        vecs.push_back(mk("quiet1",     0, 1, 0,  7,  0,  7,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("add9",       0, 1, 0,  7,  0,  7,  9,  1, 2, 2'd0, 0));
        vecs.push_back(mk("beq_t0",     0, 1, 9,  0,  0,  0,  0,  0, 0, 2'd0, 1));
        vecs.push_back(mk("beq_t0_rel", 0, 1, 9,  0,  0,  0,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("add9b",      0, 1, 0,  7,  0,  7,  9,  1, 2, 2'd0, 0));
        vecs.push_back(mk("beq_t1",     0, 1, 9,  1,  0,  7,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("lw5",        0, 1, 0,  7,  0,  7,  5,  1, 3, 2'd0, 0));
        vecs.push_back(mk("rt_use_e",   0, 1, 0,  7,  5,  1,  0,  0, 0, 2'd0, 1));
        vecs.push_back(mk("rt_eq_m",    0, 1, 0,  7,  5,  1,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("lw0",        0, 1, 0,  7,  0,  7,  0,  1, 3, 2'd0, 0));
        vecs.push_back(mk("r0_guard",   0, 1, 0,  0,  0,  0,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("quiet2",     0, 1, 0,  7,  0,  7,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("tnew0",      0, 1, 0,  7,  0,  7,  7,  1, 0, 2'd0, 0));
        vecs.push_back(mk("sat_e",      0, 1, 7,  0,  0,  7,  0,  0, 0, 2'd0, 0));
        vecs.push_back(mk("sat_m",      0, 1, 7,  0,  0,  7,  0,  0, 0, 2'd0, 0));

        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // Divide, then mflo waits 10 cycles.
        cyc("div_rst", 1, 0, 0, 7, 0, 0, 0, 2'd0, 0);
        cyc("div",     0, 1, 0, 7, 0, 0, 0, 2'd2, 0);
        for (int i = 0; i <= 10; i++) cyc("div_mflo", 0, 1, 0, 7, 0, 0, 0, 2'd3, (i < 10));
`ifdef HAZARD_STALL_CNT_EN
        check_cnt("cnt_div", 32'd10);
        cyc("cnt_rst", 1, 0, 0, 7, 0, 0, 0, 2'd3, 0);
        check_cnt("cnt_rst", 32'd0);
`endif

        // Multiply, then mflo waits 5 cycles.
        cyc("mul_rst", 1, 0, 0, 7, 0, 0, 0, 2'd0, 0);
        cyc("mult",    0, 1, 0, 7, 0, 0, 0, 2'd1, 0);
        for (int i = 0; i <= 5; i++) cyc("mul_mflo", 0, 1, 0, 7, 0, 0, 0, 2'd3, (i < 5));

        // Data and MD hazards overlap: still one stall line.
        cyc("both_rst", 1, 0, 0, 7, 0, 0, 0, 2'd0, 0);
        cyc("both_div", 0, 1, 0, 7, 0, 0, 0, 2'd2, 0);
        cyc("both_lw6", 0, 1, 0, 7, 6, 1, 3, 2'd0, 0);
        for (int i = 0; i <= 9; i++) cyc("both_use", 0, 1, 6, 0, 0, 0, 0, 2'd3, (i < 9));

        // Reset three cycles into a divide with mflo waiting.
        cyc("mid_rst0", 1, 0, 0, 7, 0, 0, 0, 2'd0, 0);
        cyc("mid_div",  0, 1, 0, 7, 0, 0, 0, 2'd2, 0);
        for (int i = 0; i < 3; i++) cyc("mid_mflo", 0, 1, 0, 7, 0, 0, 0, 2'd3, 1);
        cyc("mid_rst",  1, 0, 0, 7, 0, 0, 0, 2'd3, 0);
        cyc("mid_after", 0, 1, 0, 7, 0, 0, 0, 2'd3, 0);
        cyc("mid_after", 0, 1, 0, 7, 0, 0, 0, 2'd3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush producer for the 5-stage pipeline. It drives the flush input of the D/E pipeline register and the hold enables of the PC and F/D register.
- Keeps its own shadow copy of the E- and M-stage destination register, write enable and Tnew. Compares each stage's Tnew against the D-stage Tuse of rs and rt.
- Tracks the multi-cycle mult/div unit with an internal busy counter and stalls dependent HI/LO instructions.

Parameters:
- MULT_CYC, 5, busy cycles loaded when mult/multu enters E
- DIV_CYC, 10, busy cycles loaded when div/divu enters E

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- rs_D_I  in  5  D-stage rs field
- rt_D_I  in  5  D-stage rt field
- Tuse_rs_D_I  in  3  cycles until D instr needs rs (7 = never)
- Tuse_rt_D_I  in  3  cycles until D instr needs rt (7 = never)
- A3_D_I  in  5  D-stage destination register
- RegWrite_D_I  in  1  D instr writes GPR
- Tnew_D_I  in  3  D-stage Tnew (same value presented to D/E register)
- md_op_D_I  in  2  00 none, 01 mult/multu, 10 div/divu, 11 mfhi/mflo/mthi/mtlo
- Stall_O  out  1  hold PC and F/D register
- Flush_DE_O  out  1  insert bubble into D/E register

Behaviour:
- Clocking: one clock; reset is synchronous and active-high; all state changes on posedge clk.
- Shadow registers: E = {A3_E, WE_E, Tnew_E}; M = {A3_M, WE_M, Tnew_M}; md_cnt, width to hold max(MULT_CYC, DIV_CYC).
- Reset: all shadow fields and md_cnt cleared to 0. Stall_O and Flush_DE_O therefore read 0 in the cycle after reset while the D inputs are quiescent.
- Shadow E update, each edge:
  - If Stall_O: E cleared to 0, mirroring the bubble.
  - Else: A3_E <= A3_D_I, WE_E <= RegWrite_D_I & (A3_D_I != 0), Tnew_E <= (Tnew_D_I != 0) ? Tnew_D_I-1 : 0.
- Shadow M update, each edge: M <= E with Tnew_M <= (Tnew_E != 0) ? Tnew_E-1 : 0. M is never frozen.
- Data hazard, combinational, for X in {E, M}:
  - stall_rs_X = WE_X & (A3_X == rs_D_I) & (rs_D_I != 0) & (Tuse_rs_D_I < Tnew_X).
  - stall_rt_X is the same with rt_D_I and Tuse_rt_D_I.
  - $0 never stalls.
  - W stage never stalls; forwarding covers it.
- MD counter, each edge, in priority order:
  1. reset -> 0.
  2. Else if !Stall_O and md_op_D_I == 01 -> MULT_CYC.
  3. Else if !Stall_O and md_op_D_I == 10 -> DIV_CYC.
  4. Else if md_cnt != 0 -> md_cnt-1.
- md_busy = (md_cnt != 0).
- MD hazard: stall_md = (md_op_D_I != 00) & md_busy.
  - A new mult/div behind a busy one stalls.
  - A new op is never loaded while stalled, so there is no overlap.
- Output combination:
  - Stall_O = OR of stall_rs_E, stall_rt_E, stall_rs_M, stall_rt_M, stall_md.
  - Flush_DE_O = Stall_O, same cycle. Both are purely combinational from current shadow state and D inputs; 0-cycle latency.
- Boundaries:
  - Tuse == Tnew does not stall; the result is forwarded.
  - Tnew of 0 saturates and never wraps.
  - Reset during an active stall or mid-divide clears all state at that edge; no residual stall afterwards.
  - Simultaneous data and MD hazards produce a single Stall_O.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt_O (32 bits), reset to 0.
  - Increments by 1 on every edge where Stall_O = 1 and reset = 0.
  - Wraps from 0xFFFF_FFFF to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - md_op encoding constants (MD_NONE, MD_MULT, MD_DIV, MD_HILO).
  - TUSE_NEVER = 3'd7.
  - Tnew width constant (3); the same package is used by the decoder and the D/E register.
- One natural sub-module, stage_hazard_cmp: combinational rs/rt vs {A3, WE, Tnew} comparison, instantiated twice (E, M).
- Counter and shadow registers stay in the top.

Test Plan:
- Load-use: lw $8 in D (Tnew_D=3, A3=8, WE=1); next cycle add using rs=8, Tuse_rs=0 -> Stall_O=Flush_DE_O=1 for 2 cycles, then 0.
- ALU-use: add $9 (Tnew_D=2); next instr beq rs=9, Tuse_rs=0 -> 1 stall cycle. Same with Tuse_rs=1 -> no stall.
- $0 guard: lw $0 followed by a reader of rs=0 with Tuse 0 -> Stall_O stays 0.
- Divide: div in D, then mflo (md_op=11) -> Stall_O=1 for 10 consecutive cycles, released on the cycle md_cnt reaches 0. Mult gives 5 cycles.
- Reset mid-op: assert reset 3 cycles into a divide with mflo waiting -> Stall_O=0 the cycle after reset, md_cnt=0.
- With HAZARD_STALL_CNT_EN defined: the divide scenario ends with stall_cnt_O=10; a reset returns it to 0.
